mux2to1_sel_arb: RTL and testbench

//  Upstream control stage for the 2:1 datapath mux: two-requester round-robin arbiter that

---
 rtl/mux2to1_sel_arb.sv | 121 ++++++++++++
 tb/tb_mux2to1_sel_arb.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mux2to1_sel_arb.sv
`default_nettype none
// ============================================================================
// Module   : mux2to1_sel_arb
// Brief    : Two-requester round-robin arbiter driving a registered 2:1 mux
//            select and per-channel grants. Optional forced release on hold
//            timeout when ARB_TIMEOUT_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module mux2to1_sel_arb #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic done,
  output logic sel,
  output logic gnt0,
  output logic gnt1,
  output logic busy,
  output logic tmo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_G0   = 2'd1,
    S_G1   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sel_q, sel_d;
  logic             gnt0_q, gnt1_q, busy_q, tmo_q;
  logic             tmo_d;
  logic             timeout_w;
  logic             rel0_w, rel1_w;

  always_comb begin
`ifdef ARB_TIMEOUT_EN
    timeout_w = (state_q != S_IDLE) && (cnt_q == CNT_MAX) && !done;
`else
    timeout_w = 1'b0;
`endif
    rel0_w  = done | ~req0 | timeout_w;
    rel1_w  = done | ~req1 | timeout_w;
    state_d = state_q;
    last_d  = last_q;
    tmo_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req0 && req1) state_d = last_q ? S_G0 : S_G1;
        else if (req0)    state_d = S_G0;
        else if (req1)    state_d = S_G1;
      end
      S_G0: begin
        if (rel0_w) begin
          last_d  = 1'b0;
          tmo_d   = timeout_w;
          state_d = req1 ? S_G1 : S_IDLE;
        end
      end
      S_G1: begin
        if (rel1_w) begin
          last_d  = 1'b1;
          tmo_d   = timeout_w;
          state_d = req0 ? S_G0 : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Counter restarts on any grant entry, including a direct hand-over.
    if ((state_d != S_IDLE) && (state_d != state_q))
      cnt_d = '0;
    else if ((state_q != S_IDLE) && (cnt_q != CNT_MAX))
      cnt_d = cnt_q + 1'b1;
    else
      cnt_d = cnt_q;

    case (state_d)
      S_G0:    sel_d = 1'b0;
      S_G1:    sel_d = 1'b1;
      default: sel_d = sel_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      gnt0_q  <= (state_d == S_G0);
      gnt1_q  <= (state_d == S_G1);
      busy_q  <= (state_d != S_IDLE);
      tmo_q   <= tmo_d;
    end
  end

  assign sel  = sel_q;
  assign gnt0 = gnt0_q;
  assign gnt1 = gnt1_q;
  assign busy = busy_q;
  assign tmo  = tmo_q;

endmodule
`default_nettype wire

// File: tb/tb_mux2to1_sel_arb.sv
`default_nettype none
// Testbench for mux2to1_sel_arb: directed scenarios plus a randomized invariant run.
module tb_mux2to1_sel_arb;

  logic clk = 1'b0;
  logic rst_n, req0, req1, done;
  logic sel, gnt0, gnt1, busy, tmo;
  logic [7:0] in0, in1, mux_o;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mux2to1_sel_arb #(.MAX_HOLD(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .done(done),
    .sel(sel), .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .tmo(tmo)
  );

  assign mux_o = sel ? in1 : in0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req0 = 1'b0; req1 = 1'b0; done = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (sel  !== 1'b0) begin n_fail++; $display("FAIL rst_sel: got %b want 0", sel); end
    n_checks++; if (gnt0 !== 1'b0) begin n_fail++; $display("FAIL rst_gnt0: got %b want 0", gnt0); end
    n_checks++; if (gnt1 !== 1'b0) begin n_fail++; $display("FAIL rst_gnt1: got %b want 0", gnt1); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_checks++; if (tmo  !== 1'b0) begin n_fail++; $display("FAIL rst_tmo: got %b want 0", tmo); end
    req1 = 1'b1;
    tick();
    n_checks++; if ({gnt1, sel, busy} !== 3'b111) begin n_fail++; $display("FAIL rst_g1_entry: got gnt1,sel,busy=%b want 111", {gnt1, sel, busy}); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if ({gnt1, sel, busy} !== 3'b000) begin n_fail++; $display("FAIL rst_async_drop: got gnt1,sel,busy=%b want 000", {gnt1, sel, busy}); end
    @(posedge clk); #1;
    rst_n = 1'b1; req1 = 1'b0; req0 = 1'b1;
    tick();
    n_checks++; if ({gnt0, gnt1, sel} !== 3'b100) begin n_fail++; $display("FAIL rst_resume_g0: got gnt0,gnt1,sel=%b want 100", {gnt0, gnt1, sel}); end
    req0 = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_release_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_tie();
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    tick();
    n_checks++; if ({gnt0, gnt1, sel} !== 3'b100) begin n_fail++; $display("FAIL tie_first_g0: got gnt0,gnt1,sel=%b want 100", {gnt0, gnt1, sel}); end
    for (int k = 0; k < 4; k++) begin
      done = 1'b0;
      tick();
      n_checks++; if ({gnt0, gnt1} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL tie_hold_%0d: got gnt0,gnt1=%b", k, {gnt0, gnt1}); end
      done = 1'b1;
      tick();
      n_checks++; if ({gnt0, gnt1, sel} !== ((k % 2 == 0) ? 3'b011 : 3'b100)) begin n_fail++; $display("FAIL tie_alt_%0d: got gnt0,gnt1,sel=%b", k, {gnt0, gnt1, sel}); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL tie_nobubble_%0d: got busy=%b want 1", k, busy); end
    end
    done = 1'b0; req0 = 1'b0; req1 = 1'b0;
    tick(); tick();
  endtask

  task automatic test_single();
    do_reset();
    req1 = 1'b1;
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 4; k++) begin
        done = (k == 3);
        tick();
        n_checks++; if (gnt1 !== (k != 3)) begin n_fail++; $display("FAIL single_gnt1_p%0d_k%0d: got %b want %b", p, k, gnt1, (k != 3)); end
        n_checks++; if (sel !== 1'b1) begin n_fail++; $display("FAIL single_sel_p%0d_k%0d: got %b want 1", p, k, sel); end
        n_checks++; if (gnt0 !== 1'b0) begin n_fail++; $display("FAIL single_gnt0_p%0d_k%0d: got %b want 0", p, k, gnt0); end
      end
    end
    done = 1'b0; req1 = 1'b0;
    tick(); tick();
  endtask

  task automatic test_timeout();
    do_reset();
    req0 = 1'b1;
`ifdef ARB_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_checks++; if ({gnt0, tmo} !== 2'b10) begin n_fail++; $display("FAIL tmo_hold_%0d: got gnt0,tmo=%b want 10", k, {gnt0, tmo}); end
    end
    tick();
    n_checks++; if ({gnt0, tmo} !== 2'b01) begin n_fail++; $display("FAIL tmo_release: got gnt0,tmo=%b want 01", {gnt0, tmo}); end
    tick();
    n_checks++; if ({gnt0, tmo} !== 2'b10) begin n_fail++; $display("FAIL tmo_pulse_end: got gnt0,tmo=%b want 10", {gnt0, tmo}); end
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_checks++; if ({gnt0, gnt1} !== 2'b10) begin n_fail++; $display("FAIL tmo2_hold_%0d: got gnt0,gnt1=%b want 10", k, {gnt0, gnt1}); end
    end
    tick();
    n_checks++; if ({gnt0, gnt1, sel, tmo} !== 4'b0111) begin n_fail++; $display("FAIL tmo2_handover: got gnt0,gnt1,sel,tmo=%b want 0111", {gnt0, gnt1, sel, tmo}); end
    do_reset();
    req0 = 1'b1;
    for (int k = 1; k <= 8; k++) tick();
    done = 1'b1;
    tick();
    n_checks++; if ({gnt0, tmo} !== 2'b00) begin n_fail++; $display("FAIL tmo_collision: got gnt0,tmo=%b want 00", {gnt0, tmo}); end
    done = 1'b0;
`else
    for (int k = 1; k <= 20; k++) begin
      tick();
      n_checks++; if ({gnt0, tmo} !== 2'b10) begin n_fail++; $display("FAIL notmo_hold_%0d: got gnt0,tmo=%b want 10", k, {gnt0, tmo}); end
    end
`endif
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick();
  endtask

  task automatic test_random();
    logic p_sel, p_g0, p_g1;
    do_reset();
    p_sel = sel; p_g0 = gnt0; p_g1 = gnt1;
    for (int i = 0; i < 10000; i++) begin
      req0 = 1'($urandom_range(0, 1));
      req1 = 1'($urandom_range(0, 1));
      done = ($urandom_range(0, 3) == 0);
      in0  = 8'($urandom);
      in1  = 8'($urandom);
      tick();
      n_checks++; if (gnt0 && gnt1) begin n_fail++; $display("FAIL rnd_excl_%0d: got gnt0,gnt1=11 want not both", i); end
      n_checks++; if (busy !== (gnt0 | gnt1)) begin n_fail++; $display("FAIL rnd_busy_%0d: got %b want %b", i, busy, gnt0 | gnt1); end
      n_checks++; if ((sel !== p_sel) && !((gnt0 && !p_g0) || (gnt1 && !p_g1))) begin n_fail++; $display("FAIL rnd_sel_glitch_%0d: sel %b->%b without grant entry", i, p_sel, sel); end
      n_checks++; if ((gnt0 && mux_o !== in0) || (gnt1 && mux_o !== in1)) begin n_fail++; $display("FAIL rnd_mux_%0d: got %h want in0=%h/in1=%h gnt=%b%b", i, mux_o, in0, in1, gnt0, gnt1); end
      p_sel = sel; p_g0 = gnt0; p_g1 = gnt1;
    end
    req0 = 1'b0; req1 = 1'b0; done = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; done = 1'b0;
    in0 = 8'h00; in1 = 8'h00;
    test_reset();
    test_tie();
    test_single();
    test_timeout();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
